// File: rtl/packet_check.sv
// AXI-Stream sink that checks generator packets (header, sequence, payload pattern)
// and keeps saturating good/bad packet counters plus sticky error flags.
module packet_check #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32,
  parameter int MAX_LEN    = 4096
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  input  logic                  ready_en,
  input  logic                  clear,
  output logic [CNT_WIDTH-1:0]  pkt_count,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic                  len_err,
  output logic                  seq_err,
  output logic                  data_err,
  output logic                  busy
);

  typedef enum logic [1:0] {
    ST_HDR     = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DRAIN   = 2'd2
  } state_t;

  localparam logic [16:0]          MAX_LEN_C = 17'(MAX_LEN);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1'b1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};

  function automatic logic [31:0] payload_word(input logic [15:0] seq, input logic [15:0] idx);
    return {seq, idx};
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt);
    return (cnt == CNT_MAX) ? cnt : (cnt + CNT_ONE);
  endfunction

  state_t               state_r;
  logic [15:0]          seq_r;
  logic [15:0]          len_r;
  logic [15:0]          beat_r;
  logic [15:0]          exp_seq_r;
  logic                 bad_r;
  logic                 busy_r;
  logic [CNT_WIDTH-1:0] pkt_count_r;
  logic [CNT_WIDTH-1:0] err_count_r;
  logic                 len_err_r;
  logic                 seq_err_r;
  logic                 data_err_r;

  logic                 accept_s;
  logic [15:0]          hdr_seq_s;
  logic [15:0]          hdr_len_s;
  logic                 hdr_len_big_s;
  logic [15:0]          last_idx_s;
  state_t               nxt_state_s;
  logic                 set_len_s;
  logic                 set_seq_s;
  logic                 set_data_s;
  logic                 done_s;
  logic                 pkt_bad_s;

  // Ready follows the enable directly so backpressure takes effect in the same cycle.
  assign s_axis_tready = ready_en & ARESETN;
  assign accept_s      = s_axis_tvalid & s_axis_tready;
  assign hdr_seq_s     = s_axis_tdata[31:16];
  assign hdr_len_s     = s_axis_tdata[15:0];
  assign hdr_len_big_s = ({1'b0, hdr_len_s} > MAX_LEN_C);
  assign last_idx_s    = len_r - 16'd1;
  assign pkt_bad_s     = bad_r | set_len_s | set_seq_s | set_data_s;

  // Per-beat decode: errors raised by this beat, packet completion and next state.
  always_comb begin
    nxt_state_s = state_r;
    set_len_s   = 1'b0;
    set_seq_s   = 1'b0;
    set_data_s  = 1'b0;
    done_s      = 1'b0;
    if (accept_s) begin
      case (state_r)
        ST_HDR: begin
          set_seq_s = (hdr_seq_s != exp_seq_r);
          done_s    = s_axis_tlast;
          if (hdr_len_big_s) begin
            set_len_s   = 1'b1;
            nxt_state_s = s_axis_tlast ? ST_HDR : ST_DRAIN;
          end else if (hdr_len_s == 16'd0) begin
            set_len_s   = ~s_axis_tlast;
            nxt_state_s = s_axis_tlast ? ST_HDR : ST_DRAIN;
          end else begin
            set_len_s   = s_axis_tlast;
            nxt_state_s = s_axis_tlast ? ST_HDR : ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          set_data_s = (s_axis_tdata != payload_word(seq_r, beat_r));
          if (s_axis_tlast) begin
            set_len_s   = (beat_r != last_idx_s);
            done_s      = 1'b1;
            nxt_state_s = ST_HDR;
          end else begin
            set_len_s   = (beat_r == last_idx_s);
            nxt_state_s = (beat_r == last_idx_s) ? ST_DRAIN : ST_PAYLOAD;
          end
        end
        ST_DRAIN: begin
          done_s      = s_axis_tlast;
          nxt_state_s = s_axis_tlast ? ST_HDR : ST_DRAIN;
        end
        default: begin
          nxt_state_s = ST_HDR;
        end
      endcase
    end else begin
      nxt_state_s = state_r;
    end
  end

  // Checker FSM, packet context, counters and sticky flags; clear overrides any update.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_r     <= ST_HDR;
      seq_r       <= 16'd0;
      len_r       <= 16'd0;
      beat_r      <= 16'd0;
      exp_seq_r   <= 16'd0;
      bad_r       <= 1'b0;
      busy_r      <= 1'b0;
      pkt_count_r <= {CNT_WIDTH{1'b0}};
      err_count_r <= {CNT_WIDTH{1'b0}};
      len_err_r   <= 1'b0;
      seq_err_r   <= 1'b0;
      data_err_r  <= 1'b0;
    end else begin
      if (accept_s) begin
        state_r <= nxt_state_s;
        busy_r  <= (nxt_state_s != ST_HDR);
        bad_r   <= done_s ? 1'b0 : pkt_bad_s;
        if (state_r == ST_HDR) begin
          seq_r  <= hdr_seq_s;
          len_r  <= hdr_len_s;
          beat_r <= 16'd0;
        end else if (state_r == ST_PAYLOAD) begin
          beat_r <= beat_r + 16'd1;
        end
      end
      if (clear) begin
        pkt_count_r <= {CNT_WIDTH{1'b0}};
        err_count_r <= {CNT_WIDTH{1'b0}};
        len_err_r   <= 1'b0;
        seq_err_r   <= 1'b0;
        data_err_r  <= 1'b0;
        exp_seq_r   <= 16'd0;
      end else begin
        // A bad sequence number resynchronises the expectation to the received one.
        if (accept_s && (state_r == ST_HDR)) begin
          exp_seq_r <= hdr_seq_s + 16'd1;
        end
        if (set_len_s) begin
          len_err_r <= 1'b1;
        end
        if (set_seq_s) begin
          seq_err_r <= 1'b1;
        end
        if (set_data_s) begin
          data_err_r <= 1'b1;
        end
        if (done_s) begin
          if (pkt_bad_s) begin
            err_count_r <= sat_inc(err_count_r);
          end else begin
            pkt_count_r <= sat_inc(pkt_count_r);
          end
        end
      end
    end
  end

  assign pkt_count = pkt_count_r;
  assign err_count = err_count_r;
  assign len_err   = len_err_r;
  assign seq_err   = seq_err_r;
  assign data_err  = data_err_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_packet_check.sv
// Directed bench for packet_check: a packet-level model checked every cycle,
// plus literal end-of-scenario expectations.
module tb_packet_check;

  localparam int CNT_W   = 4;
  localparam int MAXL    = 8;
  localparam int CNT_SAT = 15;

  logic             ACLK = 1'b0;
  logic             ARESETN = 1'b0;
  logic [31:0]      s_axis_tdata = 32'd0;
  logic             s_axis_tvalid = 1'b0;
  logic             s_axis_tlast = 1'b0;
  logic             s_axis_tready;
  logic             ready_en = 1'b0;
  logic             clear = 1'b0;
  logic [CNT_W-1:0] pkt_count;
  logic [CNT_W-1:0] err_count;
  logic             len_err;
  logic             seq_err;
  logic             data_err;
  logic             busy;

  packet_check #(.DATA_WIDTH(32), .CNT_WIDTH(CNT_W), .MAX_LEN(MAXL)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .ready_en(ready_en), .clear(clear),
    .pkt_count(pkt_count), .err_count(err_count),
    .len_err(len_err), .seq_err(seq_err), .data_err(data_err), .busy(busy)
  );

  always #5 ACLK = ~ACLK;

  int n_vec = 0;
  int n_err = 0;
  bit gap_en = 1'b0;
  bit rand_ready = 1'b0;

  // Packet-level model: beats of the current packet are collected up to tlast.
  logic [31:0] pkt_q[$];
  int          m_pkt = 0;
  int          m_err = 0;
  bit          m_len = 1'b0;
  bit          m_seq = 1'b0;
  bit          m_data = 1'b0;
  bit          m_bad = 1'b0;
  logic [15:0] m_exp = 16'd0;
  logic [15:0] m_hseq = 16'd0;
  logic [15:0] m_hlen = 16'd0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    pkt_q.delete();
    m_pkt = 0; m_err = 0; m_len = 1'b0; m_seq = 1'b0; m_data = 1'b0;
    m_bad = 1'b0; m_exp = 16'd0;
  endtask

  task automatic model_beat(input logic [31:0] d, input logic l);
    int i;
    int k;
    pkt_q.push_back(d);
    i = pkt_q.size() - 1;
    if (i == 0) begin
      m_hseq = d[31:16];
      m_hlen = d[15:0];
      if (m_hseq != m_exp) begin m_seq = 1'b1; m_bad = 1'b1; end
      m_exp = m_hseq + 16'd1;
      if (int'(m_hlen) > MAXL || (m_hlen == 16'd0 && !l) || (m_hlen != 16'd0 && l)) begin
        m_len = 1'b1; m_bad = 1'b1;
      end
    end else begin
      k = i - 1;
      if (int'(m_hlen) <= MAXL && k < int'(m_hlen)) begin
        if (d != {m_hseq, 16'(k)}) begin m_data = 1'b1; m_bad = 1'b1; end
        if ((l && k != int'(m_hlen) - 1) || (!l && k == int'(m_hlen) - 1)) begin
          m_len = 1'b1; m_bad = 1'b1;
        end
      end
    end
    if (l) begin
      if (m_bad) m_err = (m_err < CNT_SAT) ? m_err + 1 : CNT_SAT;
      else       m_pkt = (m_pkt < CNT_SAT) ? m_pkt + 1 : CNT_SAT;
      m_bad = 1'b0;
      pkt_q.delete();
    end
  endtask

  initial begin
    forever begin
      @(posedge ACLK);
      if (!ARESETN) begin
        model_reset();
      end else begin
        if (s_axis_tvalid && ready_en) model_beat(s_axis_tdata, s_axis_tlast);
        if (clear) begin
          m_pkt = 0; m_err = 0; m_len = 1'b0; m_seq = 1'b0; m_data = 1'b0; m_exp = 16'd0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge ACLK);
      check("tready", int'(s_axis_tready), int'(ready_en && ARESETN));
      check("pkt_count", int'(pkt_count), m_pkt);
      check("err_count", int'(err_count), m_err);
      check("len_err", int'(len_err), int'(m_len));
      check("seq_err", int'(seq_err), int'(m_seq));
      check("data_err", int'(data_err), int'(m_data));
      check("busy", int'(busy), int'(pkt_q.size() > 0));
    end
  end

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic l);
    int waited = 0;
    bit acc;
    if (gap_en && $urandom_range(0, 2) == 0) begin
      s_axis_tvalid = 1'b0;
      if (rand_ready) ready_en = 1'($urandom_range(0, 1));
      step();
    end
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    if (rand_ready) ready_en = 1'($urandom_range(0, 1));
    forever begin
      @(posedge ACLK);
      acc = ready_en && ARESETN;
      #1;
      if (acc) break;
      waited++;
      if (waited > 20) ready_en = 1'b1;
      else if (rand_ready) ready_en = 1'($urandom_range(0, 1));
      if (waited > 40) begin
        n_vec++; n_err++;
        $display("FAIL accept_timeout: beat %h not accepted after %0d cycles", d, waited);
        break;
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic send_pkt(input logic [15:0] seq, input int len);
    send_beat({seq, 16'(len)}, len == 0);
    for (int k = 0; k < len; k++) send_beat({seq, 16'(k)}, k == len - 1);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic expect_lit(input string name, input int p, input int e,
                            input int le, input int se, input int de);
    @(negedge ACLK);
    check({name, ".pkt"}, int'(pkt_count), p);
    check({name, ".err"}, int'(err_count), e);
    check({name, ".len"}, int'(len_err), le);
    check({name, ".seq"}, int'(seq_err), se);
    check({name, ".data"}, int'(data_err), de);
    check({name, ".busy"}, int'(busy), 0);
    @(posedge ACLK);
    #1;
  endtask

  initial begin
    ready_en = 1'b1;
    step(); step();
    check("reset.tready", int'(s_axis_tready), 0);
    expect_lit("reset", 0, 0, 0, 0, 0);
    ARESETN = 1'b1;
    step();

    for (int s = 0; s < 3; s++) send_pkt(16'(s), 4);
    expect_lit("three_good", 3, 0, 0, 0, 0);

    gap_en = 1'b1;
    send_beat(32'h0005_0002, 1'b0);
    send_beat(32'h0005_0000, 1'b0);
    send_beat(32'h0005_0001, 1'b1);
    send_pkt(16'd6, 1);
    expect_lit("seq_resync", 4, 1, 0, 1, 0);
    gap_en = 1'b0;
    pulse_clear();

    send_beat(32'h0000_0004, 1'b0);
    send_beat(32'h0000_0000, 1'b0);
    send_beat(32'h0000_0001, 1'b0);
    send_beat(32'h0000_0007, 1'b0);
    send_beat(32'h0000_0003, 1'b1);
    expect_lit("data_bad", 0, 1, 0, 0, 1);
    pulse_clear();

    send_beat(32'h0000_0004, 1'b0);
    send_beat(32'h0000_0000, 1'b0);
    send_beat(32'h0000_0001, 1'b1);
    send_pkt(16'd1, 2);
    expect_lit("early_last", 1, 1, 1, 0, 0);
    pulse_clear();

    send_beat(32'h0000_0002, 1'b0);
    for (int k = 0; k < 4; k++) send_beat({16'h0000, 16'(k)}, k == 3);
    send_pkt(16'd1, 1);
    expect_lit("drain", 1, 1, 1, 0, 0);
    pulse_clear();

    gap_en = 1'b1;
    send_pkt(16'd0, MAXL);
    send_beat({16'd1, 16'(MAXL + 1)}, 1'b1);
    send_beat({16'd2, 16'(MAXL + 1)}, 1'b0);
    send_beat(32'h0002_0000, 1'b0);
    send_beat(32'h0002_0001, 1'b1);
    send_beat(32'h0003_0000, 1'b0);
    send_beat(32'h0003_0000, 1'b1);
    send_pkt(16'hFFFF, 0);
    send_pkt(16'h0000, 1);
    expect_lit("bounds_wrap", 2, 4, 1, 1, 0);
    gap_en = 1'b0;
    pulse_clear();

    gap_en = 1'b1;
    rand_ready = 1'b1;
    for (int s = 0; s < 3; s++) send_pkt(16'(s), 0);
    send_pkt(16'd3, 2);
    gap_en = 1'b0;
    rand_ready = 1'b0;
    ready_en = 1'b1;
    clear = 1'b1;
    send_beat(32'h0004_0000, 1'b1);
    clear = 1'b0;
    expect_lit("clear_on_done", 0, 0, 0, 0, 0);

    for (int s = 0; s < 18; s++) send_pkt(16'(s), 0);
    for (int s = 0; s < 17; s++) send_pkt(16'h0100, 0);
    expect_lit("saturate", CNT_SAT, CNT_SAT, 0, 1, 0);
    pulse_clear();

    send_beat(32'h0000_0004, 1'b0);
    send_beat(32'h0000_0000, 1'b0);
    send_beat(32'h0000_0001, 1'b0);
    ARESETN = 1'b0;
    model_reset();
    step();
    expect_lit("mid_reset", 0, 0, 0, 0, 0);
    ARESETN = 1'b1;
    step();
    send_pkt(16'd0, 1);
    expect_lit("after_reset", 1, 0, 0, 0, 0);
    pulse_clear();

    send_beat(32'h0000_0003, 1'b0);
    send_beat(32'hDEAD_0000, 1'b0);
    pulse_clear();
    send_beat(32'h0000_0001, 1'b0);
    send_beat(32'h0000_0002, 1'b1);
    expect_lit("clear_mid_pkt", 0, 1, 0, 0, 0);

    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/packet_check.md
Name: packet_check

Overview:
- AXI-Stream sink placed directly downstream of the packet generator.
- Receives generated packets and checks header, sequence and payload pattern; counts good and bad packets.
- Exposes counters and sticky error flags for the AXI-Lite register block to read.
- Lets the bench and on-board self-test close the loop on generator output.

Parameters:
- DATA_WIDTH, 32, stream data width; fixed 32, other values unsupported.
- CNT_WIDTH, 32, width of the packet and error counters.
- MAX_LEN, 4096, largest legal payload length in beats; header length above this is a length error.

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  asynchronous active-low reset.
- s_axis_tdata  in  32  stream data.
- s_axis_tvalid  in  1  stream valid.
- s_axis_tlast  in  1  last beat of packet.
- s_axis_tready  out  1  stream ready; equals ready_en when not in reset.
- ready_en  in  1  backpressure control, from register or bench.
- clear  in  1  one-cycle pulse; zeroes counters and flags, and resets expected sequence to 0.
- pkt_count  out  CNT_WIDTH  packets received error-free.
- err_count  out  CNT_WIDTH  packets with at least one error.
- len_err  out  1  sticky: header length mismatch or out of range.
- seq_err  out  1  sticky: sequence number mismatch.
- data_err  out  1  sticky: payload pattern mismatch.
- busy  out  1  high while mid-packet (state not HDR).

Behaviour:
- Beat accepted only when s_axis_tvalid and s_axis_tready are both high.
- Register outputs are updated on the cycle after the deciding beat.

Packet format:
- Beat 0 (header): [31:16] seq, [15:0] len (payload beats).
- Payload beat k, for k = 0..len-1: data = {seq, k[15:0]}.
- Header has tlast=1 iff len==0; otherwise tlast only on payload beat len-1.

Reset state (ARESETN low, asynchronous):
- State = HDR; counters = 0; flags = 0; exp_seq = 0; beat counter = 0.
- s_axis_tready = 0; busy = 0.

State HDR:
- On header accept, latch seq and len.
- seq != exp_seq -> set seq_err, mark packet bad.
- Set exp_seq = header seq + 1, wrapping 16 bits; resynchronises on a bad seq.
- len > MAX_LEN -> set len_err, mark bad, go to DRAIN, or finish immediately if tlast.
- len==0 and tlast=1 -> packet done.
- len==0 and tlast=0 -> len_err, go to DRAIN.
- len>0 and tlast=1 -> len_err, packet done (bad).
- Otherwise -> PAYLOAD with beat counter k = 0.

State PAYLOAD, per accepted beat:
- data != {seq, k} -> data_err, mark bad; continue checking.
- tlast=1 and k != len-1 -> len_err, done.
- k == len-1 and tlast=0 -> len_err, go to DRAIN.
- k == len-1 and tlast=1 -> done.
- Otherwise k++.

State DRAIN:
- Accept and discard beats, with no data checks, until tlast; then done.

Packet done:
- Bad -> err_count++; good -> pkt_count++.
- Return to HDR.
- Exactly one counter increments per packet.
- Counters saturate at all-ones; they do not wrap.

Clear:
- clear has priority over a simultaneous count or flag update in the same cycle.
- Does not change state; a packet in flight continues to be checked, and its outcome counts after the clear.
- Flags are sticky until clear or reset.

Other rules:
- tvalid low or tready low stalls the checker with no state change; gaps are legal anywhere.
- Reset mid-packet: immediate return to HDR. The next accepted beat is treated as a header; leftover beats of the interrupted packet produce errors, which is accepted behaviour.
- Throughput is one beat per cycle with no bubbles between packets.

Test Plan:
- Three packets, seq 0,1,2, len 4, correct payload, ready_en=1 -> pkt_count=3, err_count=0, all flags 0, busy=0 at end.
- Header 0x0005_0002 while exp_seq=3, correct payload -> seq_err=1, err_count=1. Next packet seq 6 -> counted good.
- Packet seq 0 len 4, payload beat 2 = 0x0000_0007 -> data_err=1, err_count=1, pkt_count=0.
- Header len 4 with tlast on payload beat 1, then a valid seq-1 packet -> len_err=1, err_count=1, pkt_count=1.
- Header len 2 with no tlast on beat 1, tlast on extra beat 3 -> DRAIN consumes the extra beats; err_count=1, and the next header is checked normally.
- Zero-length header 0x0000_0000 with tlast, ready_en toggled randomly throughout, then clear pulsed on the same cycle as a completing packet -> counters read 0 after clear, s_axis_tready tracks ready_en.
